pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register. Successor to the fixed-field stage registers.
- Carries an opaque Width-bit payload between pipeline stages with a valid/ready handshake, flush, and an optional 2-entry skid buffer.
- The skid buffer registers the backpressure path, so a stall does not ripple combinationally upstream.
- Instantiated between IF/ID/EX/MEM/WB. Each stage packs its control and data fields into the payload.

Parameters:
- Width, 32, payload width in bits (>=1).
- Skid, 1: 1 = two-entry skid buffer with registered in_ready_o; 0 = single-entry register with combinational in_ready_o.
- ZeroOnFlush, 1: 1 = data registers cleared to 0 on flush; 0 = data held, only valid cleared.
- CntWidth, 16, stall counter width (used only with the optional feature).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous, active-high reset.
- flush_i  input  1  kill all held entries (branch mispredict / trap).
- in_valid_i  input  1  upstream payload valid.
- in_ready_o  output  1  stage can accept a payload.
- in_data_i  input  Width  upstream payload.
- out_valid_o  output  1  downstream payload valid.
- out_ready_i  input  1  downstream accepts.
- out_data_o  output  Width  payload to the next stage.
- stall_cnt_o  output  CntWidth  present only with PIPE_STAGE_PERF_EN.

Behaviour:
- Handshakes:
  - in_fire = in_valid_i & in_ready_o.
  - out_fire = out_valid_o & out_ready_i.
- Reset (rst_i=1 sampled at clk edge), regardless of other inputs:
  - out_valid_o=0, out_data_o=0, skid entry invalid and 0.
  - in_ready_o=1 from the first cycle after reset.
  - stall_cnt_o=0.
- Priority: rst_i > flush_i > normal operation.
- Flush (flush_i=1):
  - All entries invalidated next cycle and state goes to EMPTY.
  - An in_fire in the same cycle is dropped, not stored.
  - If ZeroOnFlush=1, main and skid data go to 0; otherwise they are held.
  - in_ready_o=1 after the flush.
- Latency: 1 cycle from in_fire to out_valid_o. Throughput is 1 payload/cycle when out_ready_i is held high.
- Stability: while out_valid_o=1 and out_ready_i=0, out_data_o and out_valid_o must not change unless flush or reset occurs.
- Skid=1, state machine (main = output register, skid = overflow register):
  - EMPTY: in_ready_o=1, out_valid_o=0.
    - in_fire -> FULL1; main<=in_data_i.
  - FULL1: in_ready_o=1, out_valid_o=1.
    - in_fire & out_fire -> FULL1; main<=in_data_i.
    - in_fire & !out_fire -> FULL2; skid<=in_data_i.
    - !in_fire & out_fire -> EMPTY.
    - Otherwise hold.
  - FULL2: in_ready_o=0, out_valid_o=1.
    - out_fire -> FULL1; main<=skid.
    - Otherwise hold.
  - in_ready_o is a flop output: it is 0 exactly in FULL2 and is never driven combinationally from out_ready_i.
  - Ordering: payloads leave in arrival order. No drop or duplication except on flush.
- Skid=0:
  - One entry only.
  - in_ready_o = !out_valid_o | out_ready_i, combinational.
  - Next state:
    - in_fire -> load data, out_valid_o=1.
    - out_fire & !in_fire -> out_valid_o=0.
  - Equivalent to the classic stage register when out_ready_i is tied to !stall.
- When no payload is loaded, data registers hold their value; they do not toggle.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt_o exists.
  - Increments by 1 each cycle out_valid_o=1 and out_ready_i=0.
  - Saturates at 2^CntWidth-1 (no wrap).
  - Cleared only by rst_i; flush does not clear it.
- Undefined:
  - Port and counter logic absent.
  - Datapath behaviour identical in both builds.

Test Plan:
1. Reset with in_valid_i=1, in_data_i=32'hDEAD_BEEF held during rst_i=1 -> out_valid_o=0, out_data_o=0, in_ready_o=1; no capture.
2. Streaming, Skid=1, out_ready_i=1, inputs 1,2,3,4 on consecutive cycles -> out_data_o = 1,2,3,4 on the following 4 cycles, each with out_valid_o=1; in_ready_o stays 1.
3. Backpressure, Skid=1: send A=0x11, B=0x22, C=0x33 with out_ready_i=0 -> A in main, B in skid, in_ready_o=0 from the cycle after B; C not accepted until released. Raise out_ready_i -> outputs 0x11, 0x22, 0x33 in order, none lost.
4. Flush in FULL2 with a simultaneous in_fire, ZeroOnFlush=1 -> next cycle out_valid_o=0, out_data_o=0, in_ready_o=1; flushed input never appears at the output.
5. Skid=0, out_ready_i toggling 1,0,1 with continuous input -> in_ready_o follows !out_valid_o|out_ready_i combinationally; no payload lost or duplicated.
6. PIPE_STAGE_PERF_EN, CntWidth=4: hold out_valid_o=1, out_ready_i=0 for 20 cycles -> stall_cnt_o reaches 15 and stays at 15; flush leaves it at 15; rst_i returns it to 0.

Source files
------------

// File: rtl/pipe_stage_if.sv
// Valid/ready handshake bundle around one pipeline stage register: the upstream side
// (in_*) and the downstream side (out_*). The slave modport is the stage; the master modport is its surroundings.
interface pipe_stage_if #(
  parameter int Width = 32
) ();
  logic             in_valid_i;
  logic             in_ready_o;
  logic [Width-1:0] in_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [Width-1:0] out_data_o;

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush and optional skid buffer.
// Optional stall counter output stall_cnt_o is built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
  parameter int Width       = 32,
  parameter int Skid        = 1,
  parameter int ZeroOnFlush = 1,
  parameter int CntWidth    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  pipe_stage_if.slave         bus
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CntWidth-1:0] stall_cnt_o
`endif
);

  if (Width < 1 || CntWidth < 1) begin : g_param_err
    $error("pipe_stage_reg: Width and CntWidth must be >= 1");
  end

  logic             vld_p1;
  logic [Width-1:0] data_p1;
  logic             rdy;

  assign bus.out_valid_o = vld_p1;
  assign bus.out_data_o  = data_p1;
  assign bus.in_ready_o  = rdy;

  if (Skid != 0) begin : g_skid
    typedef enum logic [1:0] {EMPTY, FULL1, FULL2} state_e;

    state_e           state_p1, state_nxt;
    logic [Width-1:0] skid_p1, skid_nxt, data_nxt;
    logic             rdy_p1;
    logic             in_fire, out_fire;

    assign in_fire  = bus.in_valid_i & rdy_p1;
    assign out_fire = vld_p1 & bus.out_ready_i;
    assign rdy      = rdy_p1;

    always_comb begin
      state_nxt = state_p1;
      data_nxt  = data_p1;
      skid_nxt  = skid_p1;
      if (flush_i) begin
        state_nxt = EMPTY;
        if (ZeroOnFlush != 0) begin
          data_nxt = '0;
          skid_nxt = '0;
        end
      end else begin
        case (state_p1)
          EMPTY: begin
            if (in_fire) begin
              state_nxt = FULL1;
              data_nxt  = bus.in_data_i;
            end
          end
          FULL1: begin
            if (in_fire && out_fire) begin
              data_nxt = bus.in_data_i;
            end else if (in_fire) begin
              state_nxt = FULL2;
              skid_nxt  = bus.in_data_i;
            end else if (out_fire) begin
              state_nxt = EMPTY;
            end
          end
          FULL2: begin
            if (out_fire) begin
              state_nxt = FULL1;
              data_nxt  = skid_p1;
            end
          end
          default: state_nxt = EMPTY;
        endcase
      end
    end

    // Stage boundary: ready and valid are registered from the next state so that
    // a downstream stall never reaches in_ready_o combinationally.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_p1 <= EMPTY;
        data_p1  <= '0;
        skid_p1  <= '0;
        rdy_p1   <= 1'b1;
        vld_p1   <= 1'b0;
      end else begin
        state_p1 <= state_nxt;
        data_p1  <= data_nxt;
        skid_p1  <= skid_nxt;
        rdy_p1   <= (state_nxt != FULL2);
        vld_p1   <= (state_nxt != EMPTY);
      end
    end
  end else begin : g_single
    logic             in_fire, out_fire;
    logic             vld_nxt;
    logic [Width-1:0] data_nxt;

    assign rdy      = !vld_p1 | bus.out_ready_i;
    assign in_fire  = bus.in_valid_i & rdy;
    assign out_fire = vld_p1 & bus.out_ready_i;

    always_comb begin
      vld_nxt  = vld_p1;
      data_nxt = data_p1;
      if (flush_i) begin
        vld_nxt = 1'b0;
        if (ZeroOnFlush != 0) data_nxt = '0;
      end else if (in_fire) begin
        vld_nxt  = 1'b1;
        data_nxt = bus.in_data_i;
      end else if (out_fire) begin
        vld_nxt = 1'b0;
      end
    end

    // Stage boundary: single output register.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_p1  <= 1'b0;
        data_p1 <= '0;
      end else begin
        vld_p1  <= vld_nxt;
        data_p1 <= data_nxt;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CntWidth-1:0] stall_cnt_p1;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Counts cycles where a held payload is refused downstream; flush leaves it alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_p1 <= '0;
    end else if (vld_p1 && !bus.out_ready_i) begin
      stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end
  end

  assign stall_cnt_o = stall_cnt_p1;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg: a skid instance (ZeroOnFlush=1) and a
// single-entry instance (ZeroOnFlush=0) run side by side against queue-based reference models.
module tb_pipe_stage_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   chk_cnt = 0;
  int   fail_cnt = 0;

  always #5 clk = ~clk;

  pipe_stage_if #(.Width(32)) sif ();
  pipe_stage_if #(.Width(32)) nif ();

`ifdef PIPE_STAGE_PERF_EN
  logic [3:0] s_cnt, n_cnt;
`endif

  pipe_stage_reg #(.Width(32), .Skid(1), .ZeroOnFlush(1), .CntWidth(4)) u_skid (
    .clk_i  (clk),
    .rst_i  (rst),
    .flush_i(flush),
    .bus    (sif.slave)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt_o(s_cnt)
`endif
  );

  pipe_stage_reg #(.Width(32), .Skid(0), .ZeroOnFlush(0), .CntWidth(4)) u_single (
    .clk_i  (clk),
    .rst_i  (rst),
    .flush_i(flush),
    .bus    (nif.slave)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt_o(n_cnt)
`endif
  );

  // Reference model: each stage is a FIFO of accepted payloads with a capacity of 2 (skid) or 1.
  logic [31:0] qs[$];
  logic [31:0] qn[$];
  int          ms_cnt = 0;
  int          mn_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic f, input logic iv,
                       input logic [31:0] d, input logic ordy);
    bit s_rdy, n_rdy, s_in, s_out, n_in, n_out, s_stall, n_stall;
    rst = r;
    flush = f;
    sif.in_valid_i = iv;  sif.in_data_i = d;  sif.out_ready_i = ordy;
    nif.in_valid_i = iv;  nif.in_data_i = d;  nif.out_ready_i = ordy;
    #1;
    s_rdy = (qs.size() < 2);
    n_rdy = (qn.size() == 0) || ordy;
    chk("s_in_ready", sif.in_ready_o, s_rdy);
    chk("s_out_valid", sif.out_valid_o, qs.size() != 0);
    if (qs.size() != 0) chk("s_out_data", sif.out_data_o, qs[0]);
    chk("n_in_ready", nif.in_ready_o, n_rdy);
    chk("n_out_valid", nif.out_valid_o, qn.size() != 0);
    if (qn.size() != 0) chk("n_out_data", nif.out_data_o, qn[0]);
    s_in    = iv && s_rdy;
    s_out   = (qs.size() != 0) && ordy;
    n_in    = iv && n_rdy;
    n_out   = (qn.size() != 0) && ordy;
    s_stall = (qs.size() != 0) && !ordy;
    n_stall = (qn.size() != 0) && !ordy;
    @(posedge clk);
    #1;
    if (r) begin
      qs.delete();
      qn.delete();
      ms_cnt = 0;
      mn_cnt = 0;
    end else begin
      if (s_stall && ms_cnt < 15) ms_cnt++;
      if (n_stall && mn_cnt < 15) mn_cnt++;
      if (f) begin
        qs.delete();
        qn.delete();
      end else begin
        if (s_out) void'(qs.pop_front());
        if (s_in) qs.push_back(d);
        if (n_out) void'(qn.pop_front());
        if (n_in) qn.push_back(d);
      end
    end
`ifdef PIPE_STAGE_PERF_EN
    chk("s_stall_cnt", {28'd0, s_cnt}, ms_cnt);
    chk("n_stall_cnt", {28'd0, n_cnt}, mn_cnt);
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
  endtask

  initial begin
    sif.in_valid_i = 1'b1; sif.in_data_i = 32'hDEAD_BEEF; sif.out_ready_i = 1'b0;
    nif.in_valid_i = 1'b1; nif.in_data_i = 32'hDEAD_BEEF; nif.out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset while a payload is offered: nothing captured, data zero
    cycle(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("rst_s_data", sif.out_data_o, 32'd0);
    chk("rst_n_data", nif.out_data_o, 32'd0);
    chk("rst_s_ready", sif.in_ready_o, 1'b1);

    // Streaming with out_ready held high
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b0, 1'b1, i, 1'b1);
    drain();

    // Backpressure: A main, B skid, C refused until release
    cycle(1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h22, 1'b0);
    chk("bp_s_ready_low", sif.in_ready_o, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h33, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h33, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'h33, 1'b1);
    drain();

    // Flush while full with a simultaneous in_fire
    cycle(1'b0, 1'b0, 1'b1, 32'h44, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h55, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h66, 1'b0);
    chk("fl_s_valid", sif.out_valid_o, 1'b0);
    chk("fl_s_data", sif.out_data_o, 32'd0);
    chk("fl_s_ready", sif.in_ready_o, 1'b1);
    chk("fl_n_valid", nif.out_valid_o, 1'b0);
    chk("fl_n_hold", nif.out_data_o, 32'h44);
    drain();

    // Toggling out_ready with continuous input
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b1, 32'h100 + i, (i % 3) != 1);
    drain();

    // Long stall: counter saturates, survives flush, cleared by reset
    cycle(1'b0, 1'b0, 1'b1, 32'h77, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
    chk("perf_sat", {28'd0, s_cnt}, 32'd15);
`endif
    cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
    chk("perf_flush", {28'd0, s_cnt}, 32'd15);
`endif
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
    chk("perf_rst", {28'd0, s_cnt}, 32'd0);
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
    $finish;
  end
endmodule
